// File: rtl/crc_lfsr_pkg.sv
// Shared types and defaults for the serial CRC engine.
// State encoding plus default 8-bit polynomial and seed.
package crc_lfsr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    OUT   = 2'd2
  } state_e;

  localparam logic [7:0] DEF_POLY = 8'hC4;
  localparam logic [7:0] DEF_SEED = 8'hD8;

endpackage

// File: rtl/crc_lfsr_step.sv
// Combinational DATA_W-bit Galois LFSR advance, data_i[0] first.
// Ports: r_i current register, data_i input bits, r_o next register.
module crc_lfsr_step
  import crc_lfsr_pkg::*;
#(
  parameter int                   CRC_WIDTH = 8,
  parameter int                   DATA_W    = 1,
  parameter logic [CRC_WIDTH-1:0] POLY      = CRC_WIDTH'(DEF_POLY)
) (
  input  logic [CRC_WIDTH-1:0] r_i,
  input  logic [DATA_W-1:0]    data_i,
  output logic [CRC_WIDTH-1:0] r_o
);

  logic [CRC_WIDTH-1:0] acc;

  always_comb begin
    acc = r_i;
    for (int i = 0; i < DATA_W; i++) begin
      if (data_i[i] ^ acc[0]) acc = (acc >> 1) ^ POLY;
      else                    acc = acc >> 1;
    end
    r_o = acc;
  end

endmodule

// File: rtl/crc_lfsr_engine.sv
// Serial CRC engine: absorbs DATA while ACTIVE, then streams CRC LSB first.
// Ports: CLK, RST (sync, high), DATA, ACTIVE in; CRC, valid, ready out.
// Option CRC_LFSR_PAR_OUT_EN adds CRC_PAR, the full result held per frame.
module crc_lfsr_engine
  import crc_lfsr_pkg::*;
#(
  parameter int                   CRC_WIDTH = 8,
  parameter int                   DATA_W    = 1,
  parameter logic [CRC_WIDTH-1:0] POLY      = CRC_WIDTH'(DEF_POLY),
  parameter logic [CRC_WIDTH-1:0] SEED      = CRC_WIDTH'(DEF_SEED)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] DATA,
  input  logic              ACTIVE,
  output logic              CRC,
  output logic              valid,
  output logic              ready
`ifdef CRC_LFSR_PAR_OUT_EN
  ,
  output logic [CRC_WIDTH-1:0] CRC_PAR
`endif
);

  localparam int CNT_W = $clog2(CRC_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CRC_WIDTH - 1);

  state_e               state_q, state_d;
  logic [CRC_WIDTH-1:0] r_q, r_d, r_step;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 crc_q, crc_d;
  logic                 valid_q, valid_d;
`ifdef CRC_LFSR_PAR_OUT_EN
  logic [CRC_WIDTH-1:0] par_q, par_d;
`endif

  crc_lfsr_step #(
    .CRC_WIDTH(CRC_WIDTH),
    .DATA_W   (DATA_W),
    .POLY     (POLY)
  ) u_step (
    .r_i   (r_q),
    .data_i(DATA),
    .r_o   (r_step)
  );

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    crc_d   = crc_q;
    valid_d = valid_q;
`ifdef CRC_LFSR_PAR_OUT_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (ACTIVE) begin
          r_d     = r_step;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (ACTIVE) begin
          r_d = r_step;
        end else begin
          // first output bit leaves on the same edge that ends the frame
          state_d = OUT;
          crc_d   = r_q[0];
          valid_d = 1'b1;
          r_d     = r_q >> 1;
          cnt_d   = CNT_LAST;
`ifdef CRC_LFSR_PAR_OUT_EN
          par_d   = r_q;
`endif
        end
      end
      OUT: begin
        if (cnt_q != '0) begin
          crc_d = r_q[0];
          r_d   = r_q >> 1;
          cnt_d = cnt_q - 1'b1;
        end else begin
          crc_d   = 1'b0;
          valid_d = 1'b0;
          r_d     = SEED;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        r_d     = SEED;
        crc_d   = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      r_q     <= SEED;
      cnt_q   <= '0;
      crc_q   <= 1'b0;
      valid_q <= 1'b0;
`ifdef CRC_LFSR_PAR_OUT_EN
      par_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      crc_q   <= crc_d;
      valid_q <= valid_d;
`ifdef CRC_LFSR_PAR_OUT_EN
      par_q   <= par_d;
`endif
    end
  end

  assign ready = (state_q != OUT);
  assign CRC   = crc_q;
  assign valid = valid_q;
`ifdef CRC_LFSR_PAR_OUT_EN
  assign CRC_PAR = par_q;
`endif

endmodule
